// File: rtl/sar_ctrl_gen2.sv
// Successive-approximation controller for the SAR ADC macro: sample/convert sequencing,
// DAC switch words, gated comparator clock and majority-vote offset-trim calibration.
module sar_ctrl_gen2 #(
    parameter int unsigned NBITS      = 8,
    parameter int unsigned TRIM_BITS  = 5,
    parameter int unsigned CAL_ITER   = 7,
    parameter int unsigned SAMPLE_CYC = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 cal,
    input  logic                 cont,
    input  logic                 comp,
    output logic                 busy,
    output logic                 valid,
    output logic [NBITS-1:0]     result,
    output logic                 sample,
    output logic [NBITS-1:0]     ctlp,
    output logic [NBITS-1:0]     ctln,
    output logic [TRIM_BITS-1:0] trim,
    output logic [TRIM_BITS-1:0] trimb,
    output logic                 clkc,
    output logic                 cal_done
);

    localparam logic [NBITS-1:0]     MaskMsb  = {1'b1, {(NBITS-1){1'b0}}};
    localparam logic [TRIM_BITS-1:0] TrimMsb  = {1'b1, {(TRIM_BITS-1){1'b0}}};
    localparam logic [3:0]           VoteHalf = 4'((CAL_ITER + 1) / 2);
    localparam logic [3:0]           CalLast  = 4'(CAL_ITER - 1);
    localparam logic [3:0]           SampLast = 4'(SAMPLE_CYC - 1);

    typedef enum logic [2:0] {
        StInit, StIdle, StSample, StConv, StCal, StDone
    } state_e;

    state_e               state_q, state_d;
    logic [NBITS-1:0]     work_q, work_d;
    logic [NBITS-1:0]     mask_q, mask_d;
    logic [NBITS-1:0]     result_q, result_d;
    logic [TRIM_BITS-1:0] trim_val_q, trim_val_d;
    logic [TRIM_BITS-1:0] trim_mask_q, trim_mask_d;
    logic [3:0]           ones_q, ones_d;
    logic [3:0]           itt_q, itt_d;
    logic [3:0]           samp_cnt_q, samp_cnt_d;
    logic                 clk_en_q, clk_en_d;
    logic                 calib_q, calib_d;
    logic                 cal_done_q, cal_done_d;

    logic                 arm;
    logic                 samp_last;
    logic                 cal_step;
    logic [3:0]           ones_sum;
    logic [NBITS-1:0]     work_next;

    assign arm       = en && ((state_q == StIdle) || (state_q == StDone && cont));
    assign samp_last = (samp_cnt_q == SampLast);
    assign cal_step  = (itt_q == CalLast);
    assign ones_sum  = ones_q + {3'b000, comp};
    assign work_next = work_q | ({NBITS{comp}} & mask_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StInit;
            work_q      <= '0;
            mask_q      <= '0;
            result_q    <= '0;
            trim_val_q  <= '0;
            trim_mask_q <= '0;
            ones_q      <= '0;
            itt_q       <= '0;
            samp_cnt_q  <= '0;
            clk_en_q    <= 1'b0;
            calib_q     <= 1'b0;
            cal_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            mask_q      <= mask_d;
            result_q    <= result_d;
            trim_val_q  <= trim_val_d;
            trim_mask_q <= trim_mask_d;
            ones_q      <= ones_d;
            itt_q       <= itt_d;
            samp_cnt_q  <= samp_cnt_d;
            clk_en_q    <= clk_en_d;
            calib_q     <= calib_d;
            cal_done_q  <= cal_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   state_d = StIdle;
            StIdle:   if (en) state_d = StSample;
            StSample: if (samp_last) state_d = calib_q ? StCal : StConv;
            StConv:   if (mask_q[0]) state_d = StDone;
            StCal:    if (cal_step && trim_mask_q[0]) state_d = StDone;
            StDone:   state_d = arm ? StSample : StIdle;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        work_d      = work_q;
        mask_d      = mask_q;
        result_d    = result_q;
        trim_val_d  = trim_val_q;
        trim_mask_d = trim_mask_q;
        ones_d      = ones_q;
        itt_d       = itt_q;
        samp_cnt_d  = samp_cnt_q;
        clk_en_d    = clk_en_q;
        calib_d     = calib_q;
        cal_done_d  = cal_done_q;

        // Shared by IDLE start and the continuous-mode re-arm out of DONE.
        if (arm) begin
            work_d     = '0;
            mask_d     = MaskMsb;
            clk_en_d   = 1'b1;
            calib_d    = cal;
            samp_cnt_d = '0;
        end

        unique case (state_q)
            StInit: trim_val_d = TrimMsb;
            StSample: begin
                samp_cnt_d = samp_cnt_q + 4'd1;
                if (samp_last && calib_q) begin
                    trim_val_d  = '0;
                    trim_mask_d = TrimMsb;
                    ones_d      = '0;
                    itt_d       = '0;
                end
            end
            StConv: begin
                work_d = work_next;
                mask_d = mask_q >> 1;
                if (mask_q[0]) begin
                    result_d = work_next;
                    clk_en_d = 1'b0;
                end
            end
            StCal: begin
                ones_d = ones_sum;
                itt_d  = itt_q + 4'd1;
                if (cal_step) begin
                    // Comparator mostly low means the offset needs this trim bit.
                    if (ones_sum < VoteHalf) trim_val_d = trim_val_q | trim_mask_q;
                    trim_mask_d = trim_mask_q >> 1;
                    ones_d      = '0;
                    itt_d       = '0;
                    if (trim_mask_q[0]) begin
                        clk_en_d   = 1'b0;
                        calib_d    = 1'b0;
                        cal_done_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy     = !(state_q inside {StIdle, StInit});
        valid    = (state_q == StDone);
        sample   = (state_q == StSample) || (state_q == StCal);
        result   = result_q;
        ctlp     = work_q | mask_q;
        ctln     = ~(work_q | mask_q);
        trim     = trim_val_q | trim_mask_q;
        trimb    = ~(trim_val_q | trim_mask_q);
        cal_done = cal_done_q;
    end

    // clk_en only moves on the rising edge, so gating with the low phase cannot glitch.
    assign clkc = ~clk & clk_en_q;

endmodule

// File: tb/tb_sar_ctrl_gen2.sv
// Randomized self-checking bench for sar_ctrl_gen2: default instance plus a 12-bit sweep
// instance, checked against an arithmetic SAR / majority-vote reference model.
module tb_sar_ctrl_gen2;

    localparam int T = 5;

    logic clk = 1'b0;
    logic rstn, en, cal, cont, comp;
    bit   sel;

    always #5 clk = ~clk;

    logic en_a, en_b;
    assign en_a = en & ~sel;
    assign en_b = en & sel;

    logic        busy_a, valid_a, sample_a, clkc_a, cal_done_a;
    logic [7:0]  result_a, ctlp_a, ctln_a;
    logic [4:0]  trim_a, trimb_a;
    logic        busy_b, valid_b, sample_b, clkc_b, cal_done_b;
    logic [11:0] result_b, ctlp_b, ctln_b;
    logic [4:0]  trim_b, trimb_b;

    sar_ctrl_gen2 dut_a (
        .clk(clk), .rstn(rstn), .en(en_a), .cal(cal), .cont(cont), .comp(comp),
        .busy(busy_a), .valid(valid_a), .result(result_a), .sample(sample_a),
        .ctlp(ctlp_a), .ctln(ctln_a), .trim(trim_a), .trimb(trimb_a),
        .clkc(clkc_a), .cal_done(cal_done_a)
    );

    sar_ctrl_gen2 #(.NBITS(12), .TRIM_BITS(5), .CAL_ITER(3), .SAMPLE_CYC(3)) dut_b (
        .clk(clk), .rstn(rstn), .en(en_b), .cal(cal), .cont(cont), .comp(comp),
        .busy(busy_b), .valid(valid_b), .result(result_b), .sample(sample_b),
        .ctlp(ctlp_b), .ctln(ctln_b), .trim(trim_b), .trimb(trimb_b),
        .clkc(clkc_b), .cal_done(cal_done_b)
    );

    logic        o_busy, o_valid, o_sample, o_clkc, o_cal_done;
    logic [15:0] o_result, o_ctlp, o_ctln;
    logic [4:0]  o_trim, o_trimb;

    always_comb begin
        if (sel) begin
            o_busy = busy_b; o_valid = valid_b; o_sample = sample_b; o_clkc = clkc_b;
            o_cal_done = cal_done_b; o_result = {4'h0, result_b}; o_ctlp = {4'h0, ctlp_b};
            o_ctln = {4'h0, ctln_b}; o_trim = trim_b; o_trimb = trimb_b;
        end else begin
            o_busy = busy_a; o_valid = valid_a; o_sample = sample_a; o_clkc = clkc_a;
            o_cal_done = cal_done_a; o_result = {8'h00, result_a}; o_ctlp = {8'h00, ctlp_a};
            o_ctln = {8'h00, ctln_a}; o_trim = trim_a; o_trimb = trimb_a;
        end
    end

    int          n_checks = 0;
    int          n_fail = 0;
    int          nb, sc, ci;
    logic [15:0] last_res [2];
    logic [15:0] codes [4];
    bit          calseq [80];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (dut %0d, t=%0t)", tag, got, exp, sel, $time);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic use_dut(input bit s);
        sel = s;
        nb  = s ? 12 : 8;
        sc  = s ? 3 : 1;
        ci  = s ? 3 : 7;
    endtask

    // n back-to-back conversions of codes[0..n-1] with an ideal comparator.
    task automatic do_conv(input int n, input bit use_cont);
        logic [15:0] trial [16];
        logic [15:0] work, code;
        int lat;
        lat  = sc + nb;
        cal  = 1'b0;
        cont = use_cont;
        en   = 1'b1;
        for (int op = 0; op < n; op++) begin
            code = codes[op];
            work = '0;
            for (int k = 0; k < nb; k++) begin
                trial[k] = work | (16'd1 << (nb - 1 - k));
                if (code >= trial[k]) work = trial[k];
            end
            for (int j = 1; j <= lat + 1; j++) begin
                tick();
                if (j == 1 && op == n - 1) en = 1'b0;
                check_eq("conv_busy", o_busy, 1);
                if (j <= sc) begin
                    check_eq("sample_ctlp", o_ctlp, trial[0]);
                    check_eq("sample_hi", o_sample, 1);
                end else if (j <= lat) begin
                    check_eq("ctlp_walk", o_ctlp, trial[j-sc-1]);
                    comp = (code >= trial[j-sc-1]);
                end
                check_eq("clkc_gate", o_clkc, (j <= lat));
                check_eq("valid_time", o_valid, (j == lat + 1));
            end
            check_eq("result", o_result, code);
            check_eq("result_sar", o_result, work);
            last_res[sel] = code;
        end
        tick();
        check_eq("idle_busy", o_busy, 0);
        check_eq("idle_valid", o_valid, 0);
        cont = 1'b0;
    endtask

    // mode 0: comp=0, 1: comp=1, 2: 1,0,1,.. restarted per trim bit, else random.
    task automatic do_cal(input int mode);
        int lat, ones, b;
        logic [4:0] exp_trim, exp_trimb;
        lat      = sc + T * ci;
        exp_trim = '0;
        for (int g = 0; g < T; g++) begin
            ones = 0;
            for (int i = 0; i < ci; i++) begin
                case (mode)
                    0:       b = 0;
                    1:       b = 1;
                    2:       b = (i % 2 == 0) ? 1 : 0;
                    default: b = int'($urandom_range(0, 1));
                endcase
                calseq[g*ci+i] = (b != 0);
                ones += b;
            end
            if (ones < (ci + 1) / 2) exp_trim[T-1-g] = 1'b1;
        end
        exp_trimb = ~exp_trim;
        cal  = 1'b1;
        cont = 1'b0;
        en   = 1'b1;
        for (int j = 1; j <= lat + 1; j++) begin
            tick();
            if (j == 1) begin
                en  = 1'b0;
                cal = 1'b0;
            end
            if (j > sc && j <= lat) comp = calseq[j-sc-1];
            check_eq("cal_sample", o_sample, (j <= lat));
            check_eq("cal_valid", o_valid, (j == lat + 1));
        end
        check_eq("cal_trim", o_trim, exp_trim);
        check_eq("cal_trimb", o_trimb, exp_trimb);
        check_eq("cal_done", o_cal_done, 1);
        check_eq("cal_result_kept", o_result, last_res[sel]);
        tick();
        check_eq("cal_idle_busy", o_busy, 0);
    endtask

    task automatic check_reset_vals;
        logic [15:0] ones_w;
        ones_w = (16'd1 << nb) - 16'd1;
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_result", o_result, 0);
        check_eq("rst_sample", o_sample, 0);
        check_eq("rst_ctlp", o_ctlp, 0);
        check_eq("rst_ctln", o_ctln, ones_w);
        check_eq("rst_trim", o_trim, 0);
        check_eq("rst_trimb", o_trimb, 5'h1f);
        check_eq("rst_clkc", o_clkc, 0);
        check_eq("rst_cal_done", o_cal_done, 0);
    endtask

    // Reset asserted during the 4th CONV cycle, then a fresh start.
    task automatic do_reset_mid;
        cal  = 1'b0;
        cont = 1'b0;
        en   = 1'b1;
        for (int j = 1; j <= sc + 4; j++) begin
            tick();
            if (j == 1) en = 1'b0;
        end
        check_eq("pre_rst_busy", o_busy, 1);
        check_eq("pre_rst_clkc", o_clkc, 1);
        rstn = 1'b0;
        #1;
        check_reset_vals();
        last_res[0] = '0;
        last_res[1] = '0;
        tick();
        rstn = 1'b1;
        tick();
        check_eq("init_trim", o_trim, 5'h10);
        codes[0] = 16'($urandom_range(0, (1 << nb) - 1));
        do_conv(1, 1'b0);
        check_eq("restart_trim", o_trim, 5'h10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; en = 1'b0; cal = 1'b0; cont = 1'b0; comp = 1'b0;
        last_res[0] = '0;
        last_res[1] = '0;
        use_dut(1'b0);
        tick();
        check_reset_vals();
        rstn = 1'b1;
        tick();
        check_eq("init_trim", o_trim, 5'h10);
        check_eq("init_ctln", o_ctln, 16'h00ff);
        check_eq("init_valid", o_valid, 0);
        check_eq("init_busy", o_busy, 0);
        use_dut(1'b1);
        check_eq("init_trim_b", o_trim, 5'h10);
        use_dut(1'b0);

        codes[0] = 16'h00a5;
        do_conv(1, 1'b0);
        repeat (4) begin
            codes[0] = 16'($urandom_range(0, 255));
            do_conv(1, 1'b0);
        end

        do_cal(0);
        do_cal(1);
        do_cal(2);
        do_cal(3);
        do_cal(3);

        codes[0] = 16'h0000; codes[1] = 16'h00ff; codes[2] = 16'h0080;
        do_conv(3, 1'b1);
        for (int i = 0; i < 4; i++) codes[i] = 16'($urandom_range(0, 255));
        do_conv(4, 1'b1);

        do_reset_mid();

        use_dut(1'b1);
        codes[0] = 16'h05a3;
        do_conv(1, 1'b0);
        do_cal(0);
        do_cal(2);
        do_cal(3);
        for (int i = 0; i < 3; i++) codes[i] = 16'($urandom_range(0, 4095));
        do_conv(3, 1'b1);
        do_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
